// File: rtl/mini_src_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mini_src_pkg : opcodes, sequencer states and strobe bundle for Mini-SRC
// Revision 1.0
// ----------------------------------------------------------------------------
package mini_src_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CLS_RFMT    = 3'd0,
    CLS_IMM     = 3'd1,
    CLS_MULDIV  = 3'd2,
    CLS_UNARY   = 3'd3,
    CLS_NOP     = 3'd4,
    CLS_HALT    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } op_class_t;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic zlo_out;
    logic zhi_out;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic y_in;
    logic c_out;
    logic lo_in;
    logic hi_in;
  } strobes_t;

  // Immediate forms reuse the ALU's register-form operation codes.
  function automatic logic [4:0] map_alu_op(input logic [4:0] op);
    case (op)
      OP_ADDI: map_alu_op = OP_ADD;
      OP_ANDI: map_alu_op = OP_AND;
      OP_ORI:  map_alu_op = OP_OR;
      default: map_alu_op = op;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_control_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_control_unit_if : instruction/memory inputs and datapath strobes
// Revision 1.0
// ----------------------------------------------------------------------------
interface alu_control_unit_if;
  logic [31:0] IR;
  logic        mem_ready;
  logic        stop;

  logic PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout, IRin;
  logic Gra, Grb, Grc, Rin, Rout, Yin, Cout, LOin, HIin;
  logic [4:0] alu_op;
  logic       run;
  logic       illegal_op;

  modport master (
    input  IR, mem_ready, stop,
    output PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout, IRin,
    output Gra, Grb, Grc, Rin, Rout, Yin, Cout, LOin, HIin,
    output alu_op, run, illegal_op
  );

  modport slave (
    output IR, mem_ready, stop,
    input  PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout, IRin,
    input  Gra, Grb, Grc, Rin, Rout, Yin, Cout, LOin, HIin,
    input  alu_op, run, illegal_op
  );
endinterface
`default_nettype wire

// File: rtl/op_class_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// op_class_decode : opcode -> instruction class and ALU opcode (combinational)
// Revision 1.0
// ----------------------------------------------------------------------------
module op_class_decode
  import mini_src_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class,
  output logic [4:0] alu_op
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:            op_class = CLS_RFMT;
      OP_ADDI, OP_ANDI, OP_ORI:                 op_class = CLS_IMM;
      OP_MUL, OP_DIV:                           op_class = CLS_MULDIV;
      OP_NEG, OP_NOT:                           op_class = CLS_UNARY;
      OP_NOP:                                   op_class = CLS_NOP;
      OP_HALT:                                  op_class = CLS_HALT;
      default:                                  op_class = CLS_ILLEGAL;
    endcase
  end

  assign alu_op = map_alu_op(opcode);

endmodule
`default_nettype wire

// File: rtl/alu_control_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_control_unit : Mini-SRC fetch/execute sequencer for ALU-class instructions
// Revision 1.0
// ----------------------------------------------------------------------------
module alu_control_unit
  import mini_src_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  alu_control_unit_if.master bus
);

  state_t     state;
  state_t     state_nxt;
  logic       t1_seen;
  op_class_t  op_class;
  logic [4:0] mapped_op;
  logic [4:0] opcode;
  state_t     boundary;
  strobes_t   s;
  logic [4:0] alu_op_c;
  logic       illegal_c;
  logic       unused_ir;

  assign opcode    = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];
  assign boundary  = bus.stop ? S_IDLE : S_T0;

  op_class_decode u_decode (
    .opcode   (opcode),
    .op_class (op_class),
    .alu_op   (mapped_op)
  );

  // t1_seen marks every T1 cycle after the first, so PCin/MARin fire once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      t1_seen <= 1'b0;
    end else begin
      state   <= state_nxt;
      t1_seen <= (state == S_T1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = bus.stop ? S_IDLE : S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   state_nxt = bus.mem_ready ? S_T2 : S_T1;
      S_T2:   state_nxt = S_T3;
      S_T3: begin
        case (op_class)
          CLS_RFMT, CLS_IMM, CLS_MULDIV, CLS_UNARY: state_nxt = S_T4;
          CLS_HALT:                                 state_nxt = S_HALT;
          default:                                  state_nxt = boundary;
        endcase
      end
      S_T4:   state_nxt = (op_class == CLS_UNARY) ? boundary : S_T5;
      S_T5:   state_nxt = (op_class == CLS_MULDIV) ? S_T6 : boundary;
      S_T6:   state_nxt = boundary;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    s         = '0;
    alu_op_c  = 5'b00000;
    illegal_c = 1'b0;
    case (state)
      S_T0: begin
        s.pc_out = 1'b1;
        s.mar_in = 1'b1;
        s.inc_pc = 1'b1;
        s.z_in   = 1'b1;
      end
      S_T1: begin
        s.zlo_out = 1'b1;
        s.read    = 1'b1;
        s.mdr_in  = 1'b1;
        s.pc_in   = ~t1_seen;
        s.mar_in  = ~t1_seen;
      end
      S_T2: begin
        s.mdr_out = 1'b1;
        s.ir_in   = 1'b1;
      end
      S_T3: begin
        case (op_class)
          CLS_RFMT, CLS_IMM, CLS_MULDIV: begin
            s.grb   = 1'b1;
            s.r_out = 1'b1;
            s.y_in  = 1'b1;
          end
          CLS_UNARY: begin
            s.grb    = 1'b1;
            s.r_out  = 1'b1;
            s.z_in   = 1'b1;
            alu_op_c = mapped_op;
          end
          CLS_ILLEGAL: illegal_c = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        case (op_class)
          CLS_RFMT, CLS_MULDIV: begin
            s.z_in   = 1'b1;
            s.grc    = 1'b1;
            s.r_out  = 1'b1;
            alu_op_c = mapped_op;
          end
          CLS_IMM: begin
            s.z_in   = 1'b1;
            s.c_out  = 1'b1;
            alu_op_c = mapped_op;
          end
          CLS_UNARY: begin
            s.zlo_out = 1'b1;
            s.gra     = 1'b1;
            s.r_in    = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        s.zlo_out = 1'b1;
        if (op_class == CLS_MULDIV) begin
          s.lo_in = 1'b1;
        end else begin
          s.gra  = 1'b1;
          s.r_in = 1'b1;
        end
      end
      S_T6: begin
        s.zhi_out = 1'b1;
        s.hi_in   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.PCout      = s.pc_out;
  assign bus.MARin      = s.mar_in;
  assign bus.IncPC      = s.inc_pc;
  assign bus.Zin        = s.z_in;
  assign bus.ZLOout     = s.zlo_out;
  assign bus.ZHIout     = s.zhi_out;
  assign bus.PCin       = s.pc_in;
  assign bus.Read       = s.read;
  assign bus.MDRin      = s.mdr_in;
  assign bus.MDRout     = s.mdr_out;
  assign bus.IRin       = s.ir_in;
  assign bus.Gra        = s.gra;
  assign bus.Grb        = s.grb;
  assign bus.Grc        = s.grc;
  assign bus.Rin        = s.r_in;
  assign bus.Rout       = s.r_out;
  assign bus.Yin        = s.y_in;
  assign bus.Cout       = s.c_out;
  assign bus.LOin       = s.lo_in;
  assign bus.HIin       = s.hi_in;
  assign bus.alu_op     = alu_op_c;
  assign bus.illegal_op = illegal_c;
  assign bus.run        = (state != S_IDLE) && (state != S_HALT);

endmodule
`default_nettype wire
